// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule: sizes, Rcon constants,
// controller state encoding and the GF(2^8) doubling helper.
package aes_pkg;

  localparam int NR    = 10;
  localparam int NK    = 4;
  localparam int KEY_W = 128;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational. The table is computed from the
// field inverse (x^254) followed by the affine transform, which keeps the
// source short and lets synthesis flatten it into a lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 = a^(2+4+...+128); zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] r;
    y = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  logic [7:0] inv;

  // Inverse then affine map.
  always_comb begin
    inv    = gf_inv(byte_i);
    byte_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. Emits round keys 0..NR one per valid/ready
// handshake; each next key is derived from the current one in one cycle.
// Optional round-key store (for reverse-order use in decryption) is enabled
// by defining AES_KEY_STORE_EN.
module aes_key_expand #(
  parameter int NR = aes_pkg::NR
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef AES_KEY_STORE_EN
  input  logic [3:0]                 rd_idx,
  output logic [0:aes_pkg::KEY_W-1]  rd_key,
`endif
  input  logic                       start,
  input  logic [0:aes_pkg::KEY_W-1]  key,
  output logic                       rk_valid,
  input  logic                       rk_ready,
  output logic [0:aes_pkg::KEY_W-1]  round_key,
  output logic [3:0]                 round_idx,
  output logic                       busy,
  output logic                       done
);
  import aes_pkg::*;

  localparam int          WORD_W   = KEY_W / NK;
  localparam logic [3:0]  LAST_IDX = 4'(NR);

  state_e             state_q;
  logic [0:KEY_W-1]   round_key_q;
  logic [0:KEY_W-1]   round_key_d;
  logic [3:0]         round_idx_q;
  logic [7:0]         rcon_q;
  logic               rk_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               hs;

  logic [0:WORD_W-1]  w0, w1, w2, w3;
  logic [0:WORD_W-1]  rot_w, sub_w, t_w;
  logic [0:WORD_W-1]  n0, n1, n2, n3;

  assign hs = rk_valid_q & rk_ready;

  assign {w0, w1, w2, w3} = round_key_q;
  assign rot_w = {w3[8:WORD_W-1], w3[0:7]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .byte_i (rot_w[8*g +: 8]),
      .byte_o (sub_w[8*g +: 8])
    );
  end

  // Rcon lands on the first (leftmost) byte of the word.
  assign t_w = sub_w ^ {rcon_q, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign round_key_d = {n0, n1, n2, n3};

  // Controller: loads the key, steps the schedule on each handshake, pulses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      rcon_q      <= RCON_INIT;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= RUN;
            round_key_q <= key;
            round_idx_q <= '0;
            rcon_q      <= RCON_INIT;
            rk_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            if (round_idx_q == LAST_IDX) begin
              state_q    <= DONE;
              rk_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              round_key_q <= round_key_d;
              round_idx_q <= round_idx_q + 4'd1;
              rcon_q      <= xtime(rcon_q);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          rk_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rk_valid  = rk_valid_q;
  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef AES_KEY_STORE_EN
  logic [0:KEY_W-1] store_q [0:NR];
  logic [0:KEY_W-1] rd_key_q;

  // Capture each round key as it is handed off; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && hs) begin
      store_q[round_idx_q] <= round_key_q;
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_q <= '0;
    end else if (rd_idx <= LAST_IDX) begin
      rd_key_q <= store_q[rd_idx];
    end else begin
      rd_key_q <= '0;
    end
  end

  assign rd_key = rd_key_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a word-level FIPS-197 key schedule
// model, a per-cycle handshake/stall/done checker, and directed scenarios
// with randomized backpressure and keys.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_KEY_STORE_EN
    .rd_idx    (rd_idx),
    .rd_key    (rd_key),
`endif
    .start     (start),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]   sbox [256];
  logic [127:0] exp_keys [11];
  int           exp_count = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box by brute-force inverse search plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] xv;
    for (int x = 0; x < 256; x++) begin
      xv  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xv, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Textbook word-array key expansion into exp_keys[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc[i/4 - 1];
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Per-cycle checker: handshake contents, stall stability, done timing, busy.
  logic         prev_final = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;

  always @(negedge clk) begin
    if (rst) begin
      prev_final = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_timing", 128'(done), 128'(prev_final));
      chk("busy_vs_valid", 128'(busy), 128'(rk_valid));
      if (prev_stall) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_key", round_key, prev_key);
        chk("stall_idx", 128'(round_idx), 128'(prev_idx));
      end
      prev_final = 1'b0;
      if (rk_valid && rk_ready) begin
        chk("hs_idx", 128'(round_idx), 128'(exp_count));
        chk("hs_key", round_key, exp_keys[(exp_count <= 10) ? exp_count : 10]);
        prev_final = (round_idx == 4'd10);
        exp_count++;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_key   = round_key;
      prev_idx   = round_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive until done appears (bounded); lat counts edges since start was driven.
  task automatic wait_done(input bit rand_ready, input bit poke, inout int lat);
    while (!done && lat < 400) begin
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && lat >= 4 && lat < 7) begin
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 128'(done), 128'(1));
    chk("keys_handed", 128'(exp_count), 128'(11));
  endtask

  task automatic run_exp(input logic [127:0] k, input bit rand_ready, input bit poke, output int lat);
    expand(k);
    exp_count = 0;
    start     = 1'b1;
    key       = k;
    rk_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    lat   = 1;
    chk("first_valid", 128'(rk_valid), 128'(1));
    chk("first_idx", 128'(round_idx), 128'(0));
    wait_done(rand_ready, poke, lat);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_key"}, round_key, 128'(0));
    chk({tag, "_idx"}, 128'(round_idx), 128'(0));
  endtask

  initial begin
    int lat;
    int n;
    logic [127:0] k1;
    logic [127:0] k2;

    rst      = 1'b1;
    start    = 1'b0;
    key      = '0;
    rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
    rd_idx   = 4'd0;
`endif

    // Pin the model itself against published values.
    build_sbox();
    chk("model_sbox00", 128'(sbox[8'h00]), 128'(8'h63));
    chk("model_sbox53", 128'(sbox[8'h53]), 128'(8'hed));
    expand(SEQ_KEY);
    chk("model_seq_r10", exp_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    expand(FIPS_KEY);
    chk("model_fips_r0", exp_keys[0], FIPS_KEY);
    chk("model_fips_r1", exp_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_r10", exp_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset state.
    repeat (3) tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();
    chk_idle_zero("idle");

    // FIPS-197 key, full throughput.
    run_exp(FIPS_KEY, 1'b0, 1'b0, lat);
    chk("done_latency", 128'(lat), 128'(12));

`ifdef AES_KEY_STORE_EN
    for (int i = 10; i >= 0; i--) begin
      rd_idx = 4'(i);
      tick();
      chk("store_read", rd_key, exp_keys[i]);
    end
    rd_idx = 4'd15;
    tick();
    chk("store_oob", rd_key, 128'(0));
    rd_idx = 4'd0;
`endif
    tick();

    // Same key under random backpressure.
    run_exp(FIPS_KEY, 1'b1, 1'b0, lat);
    tick();

    // Reset in the middle of an expansion.
    expand(FIPS_KEY);
    exp_count = 0;
    start     = 1'b1;
    key       = FIPS_KEY;
    rk_ready  = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 50) begin
      tick();
      n++;
    end
    chk("reached_idx5", 128'(round_idx), 128'(5));
    rst = 1'b1;
    tick();
    chk_idle_zero("midreset");
    rst = 1'b0;
    tick();
    chk_idle_zero("post_reset");
    run_exp(SEQ_KEY, 1'b0, 1'b0, lat);
    chk("seq_latency", 128'(lat), 128'(12));
    tick();

    // start pulses with other keys while RUN must be ignored.
    run_exp(FIPS_KEY, 1'b1, 1'b1, lat);
    tick();

    // Back-to-back: start held high across done.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    expand(k1);
    exp_count = 0;
    start     = 1'b1;
    key       = k1;
    rk_ready  = 1'b1;
    tick();
    lat = 1;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    chk("b2b_first_done", 128'(done), 128'(1));
    chk("b2b_first_count", 128'(exp_count), 128'(11));
    tick();
    chk("b2b_no_accept_in_done", 128'(rk_valid), 128'(0));
    chk("b2b_idle_busy", 128'(busy), 128'(0));
    k2 = {$urandom, $urandom, $urandom, $urandom};
    key = k2;
    expand(k2);
    exp_count = 0;
    tick();
    chk("b2b_second_valid", 128'(rk_valid), 128'(1));
    chk("b2b_second_key0", round_key, k2);
    start = 1'b0;
    lat   = 2;
    wait_done(1'b1, 1'b0, lat);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule generator. It accepts a 128-bit cipher key and produces the 11 round keys (rounds 0..10), one per handshake, on a valid/ready stream. The stream feeds the round-key input of the round-key XOR stage in the encryption datapath. Each new round key is derived from the previous one in a single cycle.

## Interface

Parameters:
- `NR`, 10 — number of rounds. Fixed for AES-128; any other value is unsupported.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request a new expansion; sampled only in IDLE.
- `key`  in  [0:127]  — cipher key; bit 0 is the MSB of byte 0; sampled on the accepted `start`.
- `rk_valid`  out  1  — `round_key` and `round_idx` are valid.
- `rk_ready`  in  1  — consumer accepts the current round key.
- `round_key`  out  [0:127]  — current round key, same bit order as `key`.
- `round_idx`  out  4  — index of the current round key, 0..10.
- `busy`  out  1  — an expansion is in progress.
- `done`  out  1  — one-cycle pulse after round key 10 is accepted.
- `rd_idx`  in  4  — store read index (only with `AES_KEY_STORE_EN`).
- `rd_key`  out  [0:127]  — store read data (only with `AES_KEY_STORE_EN`).

## Operation

- **States:**
  - IDLE: `busy`=0, `rk_valid`=0.
  - RUN: `busy`=1, `rk_valid`=1.
  - DONE: one cycle, `done`=1, `busy`=0.
  - DONE always returns to IDLE on the next cycle.
- **IDLE → RUN** on `start`=1:
  - Register `key` as round key 0.
  - Set `round_idx`=0 and the Rcon register to 0x01.
- **RUN, advance:** on `rk_valid & rk_ready` with `round_idx` < 10, the next round key is computed from the current one (words w0..w3):
  - t = SubWord(RotWord(w3)) ^ {Rcon,00,00,00}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - `round_idx` increments by 1.
  - Rcon updates by xtime: shift left 1; if bit 7 was set, XOR with 0x1B. The sequence is 01 02 04 08 10 20 40 80 1B 36.
- **RUN, stall:** with no handshake, `round_key`, `round_idx` and Rcon hold their values.
- **RUN → DONE:** on the handshake with `round_idx`=10. `rk_valid` drops in the same edge.
- **`start` outside IDLE:** ignored, including in the DONE cycle.
- **Reset** (including mid-expansion): return to IDLE. `rk_valid`, `busy`, `done` = 0; `round_key` = 0; `round_idx` = 0; Rcon = 0x01. The stored keys are invalidated.

## Timing

- Latency from accepted `start` to `rk_valid`=1 with round key 0: 1 cycle.
- Throughput: one round key per cycle while `rk_ready`=1. Minimum expansion time is 11 cycles from the first `rk_valid`.
- The `done` pulse occurs the cycle after the final handshake.
- Earliest next `start` acceptance: the cycle after `done`.
- All outputs are registered. The SubWord S-box path is combinational between registers.

## Configuration

- **`AES_KEY_STORE_EN` defined:**
  - Adds an 11 × 128-bit register file. Round key i is written on its handshake.
  - `rd_key` = store[`rd_idx`], registered, 1-cycle latency.
  - `rd_idx` > 10 returns 0.
  - Contents are valid only after `done`. Reset and a new `start` do not clear the array.
  - Intended for decryption, which needs round keys in reverse order.
- **`AES_KEY_STORE_EN` undefined:**
  - The `rd_idx` and `rd_key` ports are absent.
  - Streaming operation is identical in both builds.

## Structure

- **Shared package `aes_pkg`:**
  - `NR`, `NK`=4, `KEY_W`=128.
  - Rcon initial value 0x01 and reduction constant 0x1B.
  - State enum {IDLE, RUN, DONE}.
  - `xtime` function.
- **Sub-module `aes_sbox`:** combinational, 8-bit in and out, forward S-box. It is instantiated 4 times for SubWord and shared with the SubBytes stage.

## Test plan

- **FIPS-197 key:** key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 throughout →
  - round 0 = the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` pulses 12 cycles after `start`.
- **Backpressure:** same key, `rk_ready` toggled pseudo-randomly → identical key sequence; outputs stable while stalled.
- **Reset mid-expansion:** reset asserted at `round_idx`=5 → next cycle all outputs 0 and state IDLE. A following `start` with key 000102030405060708090a0b0c0d0e0f → round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- **`start` while busy:** assert `start` with a different key during RUN → ignored; the sequence matches the original key.
- **Back-to-back expansions:** `start` held continuously → new expansion accepted the cycle after `done`, never during DONE.
- **`AES_KEY_STORE_EN`:** after the FIPS-197 expansion, read `rd_idx` 10..0 → the 11 keys in reverse order, each 1 cycle after its index; `rd_idx`=15 → 0.
